prbs5_checker: RTL and testbench
================================

# prbs5_checker

Serial PRBS-5 checker: the receive end of the 5-bit internal-XOR (Galois) LFSR pattern generator. It accepts one bit per valid cycle and self-synchronises to the x^5+x^2+1 sequence without needing the generator's seed. Once locked, it flags and counts bit errors. It sits on the test/BIST path opposite the generator and is used to check serial links and datapaths for bit integrity.

## Interface
- CNT_W, 16: width of the saturating error counter.
- LOCK_N, 8: consecutive correct predictions required to declare lock (1..255).
- LOSS_N, 4: consecutive mispredictions in LOCKED that drop lock (1..15).
- clk  in  1  single clock; everything is rising-edge.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  in_bit carries a sequence bit this cycle.
- in_bit  in  1  received bit; equals generator's s_reg[4] of the corresponding cycle.
- clear_cnt  in  1  synchronous clear of err_count.
- locked  out  1  checker is in LOCKED state.
- err_pulse  out  1  one-cycle flag: the previous accepted bit was an error while locked.
- err_count  out  CNT_W  saturating count of errors detected while locked.

## Operation
- Sequence recurrence: b[n] = b[n-3] XOR b[n-5].
- 5-bit history hist, with hist[0] the newest bit. Prediction pred = hist[2] XOR hist[4].
- Only cycles with in_valid=1 advance any state. Cycles with in_valid=0 hold everything, and err_pulse is 0.
- States:
  - HUNT: shift in_bit into hist. Increment fill from 0 to 5. When fill reaches 5, go to SYNC with match_cnt=0.
  - SYNC: compare in_bit to pred, then shift in_bit into hist (self-synchronising). A match with a non-zero hist increments match_cnt. A mismatch, or any bit taken while hist==0, clears match_cnt. When match_cnt reaches LOCK_N, go to LOCKED with miss_cnt=0.
  - LOCKED: compare in_bit to pred, then shift **pred** (not in_bit) into hist, so the local sequence free-runs and each corrupted bit counts once.
    - Mismatch: err_pulse=1 next cycle, err_count+1 (saturate at 2^CNT_W-1), miss_cnt+1. If miss_cnt reaches LOSS_N, go to HUNT with fill=0 and hist kept.
    - Match: clear miss_cnt.
- The all-zero stream never locks, because hist==0 blocks match counting.
- clear_cnt: err_count becomes 0 next edge. clear_cnt has priority over a simultaneous increment, so the result is 0 and that error is lost. err_pulse is still asserted. clear_cnt has no effect on FSM state.
- Errors in HUNT and SYNC are never counted.

## Timing
- Reset values: state=HUNT, hist=0, fill=0, match_cnt=0, miss_cnt=0, locked=0, err_pulse=0, err_count=0.
- All outputs are registered and free of combinational paths from the inputs.
- Lock latency on a clean, continuous stream: 5 fill bits + LOCK_N matches. With the defaults that is 13 valid bits; locked=1 in the cycle after the 13th valid bit is accepted.
- err_pulse and the err_count increment appear 1 cycle after the offending bit's valid cycle.
- Loss of lock: locked=0 in the cycle after the LOSS_N-th consecutive miss. That miss is itself counted.
- Relock after loss uses the full HUNT sequence again: 5 fills + LOCK_N matches.
- rst asserted mid-operation clears all state and outputs immediately, without waiting for a clock edge. Operation resumes on the first edge after rst deasserts.
- Throughput is 1 bit per clock, with no back-pressure.

## Test plan
- Clean run: generator seeded 5'b10101, in_valid=1 for 200 cycles -> locked rises after the 13th bit; err_count=0; err_pulse never asserted.
- Single error: invert bit 60 of the locked stream -> exactly one err_pulse, 1 cycle later; err_count=1; locked stays 1; bit 61 onward are error-free.
- Loss and relock: invert bits 80–83 -> err_count=4; locked=0 after bit 83; clean bits afterward -> locked=1 again after 13 more bits.
- Degenerate input: in_bit=0 for 100 valid cycles, then in_bit=1 for 100 valid cycles -> locked stays 0 throughout; err_count=0.
- Gapped input: same stream as the clean run with in_valid random at 50% -> lock after the 13th *valid* bit; err_count=0.
- Counter edges, with CNT_W=4:
  - 20 isolated errors spaced 10 bits apart -> err_count saturates at 15.
  - clear_cnt in the same cycle as an error's increment -> err_count=0 and err_pulse=1.
  - rst pulsed while locked -> locked, err_count and err_pulse go to 0 without a clock edge.

Source files
------------

// File: rtl/prbs5_checker.sv
// prbs5_checker: self-synchronising receive-side checker for the PRBS-5
// sequence b[n] = b[n-3] ^ b[n-5]. It hunts for five history bits, checks
// that enough predictions come true, and then free-runs its own copy of the
// sequence so that every corrupted bit is flagged and counted exactly once.
module prbs5_checker #(
  parameter int CNT_W  = 16,
  parameter int LOCK_N = 8,
  parameter int LOSS_N = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic             in_bit,
  input  logic             clear_cnt,
  output logic             locked,
  output logic             err_pulse,
  output logic [CNT_W-1:0] err_count
);

  typedef enum logic [1:0] {
    HUNT   = 2'd0,
    SYNC   = 2'd1,
    LOCKED = 2'd2
  } state_t;

  localparam logic [7:0] LOCK_V = 8'(LOCK_N);
  localparam logic [3:0] LOSS_V = 4'(LOSS_N);

  state_t           state, state_nxt;
  logic [4:0]       hist, hist_nxt;
  logic [2:0]       fill, fill_nxt;
  logic [7:0]       match_cnt, match_nxt;
  logic [3:0]       miss_cnt, miss_nxt;
  logic             err_nxt;
  logic [CNT_W-1:0] cnt_nxt;
  logic             pred;
  logic             mis;

  // Saturating increment: the counter parks at all-ones instead of wrapping.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    if (v == {CNT_W{1'b1}}) begin
      return v;
    end
    return v + 1'b1;
  endfunction

  // Next-state logic: only valid cycles advance; the counter clear wins over an increment.
  always_comb begin
    state_nxt = state;
    hist_nxt  = hist;
    fill_nxt  = fill;
    match_nxt = match_cnt;
    miss_nxt  = miss_cnt;
    err_nxt   = 1'b0;
    cnt_nxt   = err_count;
    pred      = hist[2] ^ hist[4];
    mis       = (in_bit != pred);
    if (in_valid) begin
      unique case (state)
        HUNT: begin
          hist_nxt = {hist[3:0], in_bit};
          fill_nxt = fill + 3'd1;
          if (fill == 3'd4) begin
            state_nxt = SYNC;
            match_nxt = '0;
          end
        end
        SYNC: begin
          // The received bit is shifted in regardless, so a wrong guess self-heals.
          hist_nxt = {hist[3:0], in_bit};
          if (!mis && (hist != 5'd0)) begin
            match_nxt = match_cnt + 8'd1;
            if ((match_cnt + 8'd1) == LOCK_V) begin
              state_nxt = LOCKED;
              miss_nxt  = '0;
            end
          end else begin
            match_nxt = '0;
          end
        end
        LOCKED: begin
          // The prediction, not the received bit, is shifted in: the local copy
          // free-runs so a single corrupted bit causes a single mismatch.
          hist_nxt = {hist[3:0], pred};
          if (mis) begin
            err_nxt  = 1'b1;
            cnt_nxt  = sat_inc(err_count);
            miss_nxt = miss_cnt + 4'd1;
            if ((miss_cnt + 4'd1) == LOSS_V) begin
              state_nxt = HUNT;
              fill_nxt  = '0;
            end
          end else begin
            miss_nxt = '0;
          end
        end
        default: begin
          state_nxt = HUNT;
          fill_nxt  = '0;
        end
      endcase
    end
    if (clear_cnt) begin
      cnt_nxt = '0;
    end
  end

  // State and output registers; outputs are registered copies of the next state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= HUNT;
      hist      <= '0;
      fill      <= '0;
      match_cnt <= '0;
      miss_cnt  <= '0;
      locked    <= 1'b0;
      err_pulse <= 1'b0;
      err_count <= '0;
    end else begin
      state     <= state_nxt;
      hist      <= hist_nxt;
      fill      <= fill_nxt;
      match_cnt <= match_nxt;
      miss_cnt  <= miss_nxt;
      locked    <= (state_nxt == LOCKED);
      err_pulse <= err_nxt;
      err_count <= cnt_nxt;
    end
  end

endmodule

// File: tb/tb_prbs5_checker.sv
// Bench for prbs5_checker: two instances (16-bit and 4-bit counters) share the
// stimulus; a queue-based reference model predicts outputs every cycle.
module tb_prbs5_checker;

  localparam int LOCK_N = 8;
  localparam int LOSS_N = 4;
  localparam int NMAX   = 400;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_bit = 1'b0;
  logic        clear_cnt = 1'b0;
  logic        locked_a, pulse_a;
  logic [15:0] cnt_a;
  logic        locked_b, pulse_b;
  logic [3:0]  cnt_b;

  int n_checks = 0;
  int n_errors = 0;

  // reference sequence and per-scenario stimulus
  bit seq   [NMAX];
  bit stim  [NMAX];
  bit clr_at[NMAX];
  // DUT observations after k valid bits accepted
  bit          dl[NMAX+1];
  bit          dp[NMAX+1];
  logic [15:0] dc[NMAX+1];
  int n_pulse_seen;
  int n_lock_seen;

  // reference model state
  bit m_hist[$];
  int m_state;   // 0 hunt, 1 sync, 2 locked
  int m_fill, m_match, m_miss, m_cnt16, m_cnt4;
  bit m_locked, m_pulse;

  prbs5_checker u_dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_bit(in_bit),
    .clear_cnt(clear_cnt), .locked(locked_a), .err_pulse(pulse_a),
    .err_count(cnt_a)
  );

  prbs5_checker #(.CNT_W(4)) u_dut4 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_bit(in_bit),
    .clear_cnt(clear_cnt), .locked(locked_b), .err_pulse(pulse_b),
    .err_count(cnt_b)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic m_reset();
    m_hist.delete();
    for (int i = 0; i < 5; i++) m_hist.push_back(1'b0);
    m_state = 0; m_fill = 0; m_match = 0; m_miss = 0;
    m_cnt16 = 0; m_cnt4 = 0; m_locked = 0; m_pulse = 0;
  endtask

  function automatic bit hist_zero();
    foreach (m_hist[i]) if (m_hist[i]) return 1'b0;
    return 1'b1;
  endfunction

  // Apply the rules to one cycle: b[n] is predicted from b[n-3] and b[n-5].
  task automatic m_update(input bit v, input bit b, input bit clr);
    bit p, z;
    m_pulse = 1'b0;
    if (v) begin
      p = m_hist[m_hist.size()-3] ^ m_hist[m_hist.size()-5];
      z = hist_zero();
      if (m_state == 0) begin
        m_hist.push_back(b);
        m_fill++;
        if (m_fill == 5) begin m_state = 1; m_match = 0; end
      end else if (m_state == 1) begin
        m_hist.push_back(b);
        if (b == p && !z) m_match++;
        else m_match = 0;
        if (m_match == LOCK_N) begin m_state = 2; m_miss = 0; end
      end else begin
        m_hist.push_back(p);
        if (b != p) begin
          m_pulse = 1'b1;
          if (m_cnt16 < 65535) m_cnt16++;
          if (m_cnt4 < 15) m_cnt4++;
          m_miss++;
          if (m_miss == LOSS_N) begin m_state = 0; m_fill = 0; end
        end else begin
          m_miss = 0;
        end
      end
      void'(m_hist.pop_front());
    end
    if (clr) begin m_cnt16 = 0; m_cnt4 = 0; end
    m_locked = (m_state == 2);
  endtask

  task automatic compare_all(input string pfx);
    chk({pfx, "_locked"},  locked_a, m_locked);
    chk({pfx, "_pulse"},   pulse_a,  m_pulse);
    chk({pfx, "_cnt16"},   cnt_a,    m_cnt16);
    chk({pfx, "_locked4"}, locked_b, m_locked);
    chk({pfx, "_pulse4"},  pulse_b,  m_pulse);
    chk({pfx, "_cnt4"},    cnt_b,    m_cnt4);
  endtask

  task automatic step(input bit v, input bit b, input bit clr);
    in_valid = v; in_bit = b; clear_cnt = clr;
    @(posedge clk);
    m_update(v, b, clr);
    #1;
    compare_all("cyc");
    if (pulse_a)  n_pulse_seen++;
    if (locked_a) n_lock_seen++;
  endtask

  // Asynchronous reset asserted mid-cycle; outputs must clear before any edge.
  task automatic do_reset();
    in_valid = 1'b0; in_bit = 1'b0; clear_cnt = 1'b0;
    #2;
    rst = 1'b1;
    m_reset();
    #1;
    compare_all("rst");
    @(posedge clk);
    #1;
    rst = 1'b0;
    for (int i = 0; i < NMAX; i++) begin stim[i] = seq[i]; clr_at[i] = 1'b0; end
    n_pulse_seen = 0;
    n_lock_seen  = 0;
  endtask

  task automatic play(input int nbits, input int valid_pct);
    int k = 0;
    int cyc = 0;
    dl[0] = locked_a; dp[0] = pulse_a; dc[0] = cnt_a;
    while (k < nbits && cyc < 5000) begin
      if ($urandom_range(99) < valid_pct) begin
        step(1'b1, stim[k], clr_at[k]);
        k++;
        dl[k] = locked_a; dp[k] = pulse_a; dc[k] = cnt_a;
      end else begin
        step(1'b0, 1'($urandom_range(1)), 1'b0);
      end
      cyc++;
    end
    if (k < nbits) chk("play_budget", k, nbits);
  endtask

  initial begin
    seq[0] = 1; seq[1] = 0; seq[2] = 1; seq[3] = 0; seq[4] = 1;
    for (int n = 5; n < NMAX; n++) seq[n] = seq[n-3] ^ seq[n-5];
    m_reset();

    // clean continuous run
    do_reset();
    play(200, 100);
    chk("clean_lock12", dl[12], 0);
    chk("clean_lock13", dl[13], 1);
    chk("clean_cnt", cnt_a, 0);
    chk("clean_pulses", n_pulse_seen, 0);

    // single error at bit 60
    do_reset();
    stim[60] = ~seq[60];
    play(200, 100);
    chk("single_cnt_before", dc[60], 0);
    chk("single_cnt_after", dc[61], 1);
    chk("single_pulse", dp[61], 1);
    chk("single_pulses", n_pulse_seen, 1);
    chk("single_locked", locked_a, 1);

    // loss of lock and relock
    do_reset();
    for (int i = 80; i <= 83; i++) stim[i] = ~seq[i];
    play(200, 100);
    chk("loss_still_locked", dl[83], 1);
    chk("loss_dropped", dl[84], 0);
    chk("loss_cnt", dc[84], 4);
    chk("relock_pre", dl[96], 0);
    chk("relock_at", dl[97], 1);
    chk("loss_cnt_end", cnt_a, 4);

    // degenerate all-zero then all-one input
    do_reset();
    for (int i = 0; i < 200; i++) stim[i] = (i >= 100);
    play(200, 100);
    chk("degen_locks", n_lock_seen, 0);
    chk("degen_cnt", cnt_a, 0);

    // gapped input
    do_reset();
    play(200, 50);
    chk("gap_lock12", dl[12], 0);
    chk("gap_lock13", dl[13], 1);
    chk("gap_cnt", cnt_a, 0);

    // saturation with 20 isolated errors
    do_reset();
    for (int i = 0; i < 20; i++) stim[20 + 10*i] = ~seq[20 + 10*i];
    play(250, 100);
    chk("sat_cnt4", cnt_b, 15);
    chk("sat_cnt16", cnt_a, 20);
    chk("sat_locked", locked_a, 1);

    // clear_cnt colliding with an error increment
    do_reset();
    stim[30] = ~seq[30];
    stim[40] = ~seq[40];
    clr_at[40] = 1'b1;
    play(60, 100);
    chk("clr_cnt_before", dc[31], 1);
    chk("clr_cnt", dc[41], 0);
    chk("clr_pulse", dp[41], 1);
    chk("clr_locked", dl[41], 1);

    // async reset while locked with a pulse up
    do_reset();
    stim[50] = ~seq[50];
    play(51, 100);
    chk("prerst_locked", locked_a, 1);
    chk("prerst_pulse", pulse_a, 1);
    do_reset();
    chk("postrst_cnt4", cnt_b, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
